pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised pipeline stage register: the successor to the fixed-field inter-stage registers between the core's IF/ID/EX/MEM/WB stages. It carries an opaque payload of configurable width with a valid/ready handshake on both sides, and obeys the controller's 6-bit `stall_i`/`flush_i` vectors at a configurable stage index. It inserts a bubble (`NOP_VAL`) whenever it drains without a new entry. Stage boundaries instantiate it with the concatenated stage fields as payload. An optional skid entry removes the combinational `out_ready_i`→`in_ready_o` path.

## Interface
Parameters:
- `DW`, 32: payload width in bits (≥1).
- `STAGE`, 2: index into `stall_i`/`flush_i` (0..5).
- `NOP_VAL`, `{DW{1'b0}}`: payload value driven while the stage holds no valid entry.

Ports:
- `clk`  in  1  the single clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  6  controller stall vector; only bit `STAGE` is used.
- `flush_i`  in  6  controller flush vector; only bit `STAGE` is used.
- `in_valid_i`  in  1  upstream offers a payload.
- `in_data_i`  in  DW  upstream payload.
- `in_ready_o`  out  1  stage accepts this cycle.
- `out_valid_o`  out  1  stage holds a valid payload.
- `out_data_o`  out  DW  held payload, or `NOP_VAL` when not valid.
- `out_ready_i`  in  1  downstream takes the payload this cycle.

## Operation
- Terms: `acc = in_valid_i && in_ready_o`; `fire = out_valid_o && out_ready_i`.
- State: main entry (`m_v`, `m_d`); with the skid buffer, one more entry (`s_v`, `s_d`).
- Flush (`flush_i[STAGE]=1`):
  - Highest priority.
  - `in_ready_o=0`.
  - Next edge: all entries become invalid and `m_d=NOP_VAL`.
  - Any `fire` in that cycle still counts for downstream.
- Stall (`stall_i[STAGE]=1`):
  - `in_ready_o=0`; the output side keeps draining.
  - If `fire` happens, the stage becomes empty and drives `NOP_VAL`, i.e. a bubble is inserted.
- Without skid:
  - `in_ready_o = !stall && !flush && (!m_v || out_ready_i)`.
  - On `acc`: `m_v=1`, `m_d=in_data_i`.
  - Else on `fire`: `m_v=0`, `m_d=NOP_VAL`.
- With skid:
  - `in_ready_o = !stall && !flush && !s_v`, which is purely registered state plus controller bits.
  - On `acc`: data goes to main if main is empty or firing; otherwise it goes to skid.
  - On `fire` with skid valid: skid moves to main and skid empties.
  - FIFO order is preserved.
- `out_data_o` always equals `m_d`; `m_d` is forced to `NOP_VAL` whenever `m_v=0`.

## Timing
- Reset values (async, immediate):
  - `m_v=0`, `s_v=0`, `m_d=NOP_VAL`.
  - `out_valid_o=0`, `out_data_o=NOP_VAL`.
  - `in_ready_o = !stall_i[STAGE] && !flush_i[STAGE]`.
- Latency: `acc` at edge N makes `out_valid_o=1` with the payload in the cycle after edge N. Throughput is 1 per cycle when `out_ready_i` is held high.
- Backpressure:
  - Without skid: `in_ready_o` falls in the same cycle as `out_ready_i` falls (while `m_v=1`).
  - With skid: `in_ready_o` falls one cycle later, after the skid fills. At most one extra entry is held.
- Simultaneous `acc` and `fire` while full (no skid): the new payload replaces the old one with no bubble.
- With skid, main full and skid empty, `acc` and `fire` together: the new payload goes to main; skid stays empty.
- Reset mid-transfer: all entries are lost and no output is produced until a new `acc`.
- `out_valid_o` never drops while `!out_ready_i`, except on flush or reset.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - The skid entry exists.
  - `in_ready_o` has no combinational dependence on `out_ready_i`.
  - Capacity is 2.
- Not defined:
  - No skid logic is built.
  - Capacity is 1.
  - `in_ready_o` depends combinationally on `out_ready_i`.
- Both builds give identical payload order and flush/stall/bubble semantics.

## Test plan
- Reset with `DW=8`, `NOP_VAL=8'hA5`, `in_valid_i=1`: during reset `out_valid_o=0` and `out_data_o=8'hA5`; the first accepted `8'h11` appears on the output exactly 1 cycle after acceptance.
- Streaming: `out_ready_i=1`, inputs `1,2,3,4` on consecutive cycles → outputs `1,2,3,4` on consecutive cycles with no gaps.
- Bubble: hold `stall_i[2]=1` while `m_d=32'h13` is valid and `out_ready_i=1` → `32'h13` fires, then `out_valid_o=0` and `out_data_o=NOP_VAL`; `in_ready_o=0` throughout.
- Flush: offer `32'hDEAD` together with `flush_i[2]=1` → `in_ready_o=0`, nothing is accepted, and the stage is empty next cycle even though an entry was held.
- Backpressure: drop `out_ready_i` for 3 cycles during a stream of `10,11,12`:
  - Without skid: `in_ready_o` falls the same cycle and nothing is lost.
  - With `PIPE_STAGE_SKID_EN`: one extra item is absorbed, then `in_ready_o=0`.
  - Both builds: output order is `10,11,12`.
- Skid flush: with skid full (`s_d=7`, `m_d=6`), assert `flush_i[STAGE]` → both entries are dropped next cycle and `in_ready_o` returns to 1 once flush and stall are low.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, controller stall/flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN to add a skid entry that decouples in_ready_o from out_ready_i.
module pipe_stage_reg #(
  parameter int            DW      = 32,
  parameter int            STAGE   = 2,
  parameter logic [DW-1:0] NOP_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    stall_i,
  input  logic [5:0]    flush_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } entry_t;

  localparam entry_t EMPTY = '{v: 1'b0, d: NOP_VAL};

  logic   stall, flush, acc, fire;
  entry_t m_q;
  logic   unused_ctl;

  assign stall       = stall_i[STAGE];
  assign flush       = flush_i[STAGE];
  assign unused_ctl  = ^{stall_i, flush_i};
  assign out_valid_o = m_q.v;
  assign out_data_o  = m_q.d;
  assign fire        = m_q.v && out_ready_i;
  assign acc         = in_valid_i && in_ready_o;

`ifdef PIPE_STAGE_SKID_EN
  entry_t s_q;

  // Readiness comes only from registered skid occupancy.
  assign in_ready_o = !stall && !flush && !s_q.v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= EMPTY;
      s_q <= EMPTY;
    end else if (flush) begin
      m_q <= EMPTY;
      s_q <= EMPTY;
    end else if (fire) begin
      if (s_q.v) begin
        // No acc is possible while skid is full, so skid simply advances.
        m_q <= s_q;
        s_q <= EMPTY;
      end else if (acc) begin
        m_q <= '{v: 1'b1, d: in_data_i};
      end else begin
        m_q <= EMPTY;
      end
    end else if (acc) begin
      if (!m_q.v) m_q <= '{v: 1'b1, d: in_data_i};
      else        s_q <= '{v: 1'b1, d: in_data_i};
    end
  end
`else
  assign in_ready_o = !stall && !flush && (!m_q.v || out_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= EMPTY;
    end else if (flush) begin
      m_q <= EMPTY;
    end else if (acc) begin
      m_q <= '{v: 1'b1, d: in_data_i};
    end else if (fire) begin
      m_q <= EMPTY;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based occupancy model checked every cycle plus directed literals.
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_00A5;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] stall_i = '0, flush_i = '0;
  logic in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic in_ready_o, out_valid_o;
  logic [DW-1:0] out_data_o;

  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DW(DW), .STAGE(2), .NOP_VAL(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (stall_i[2] || flush_i[2]) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return q.size() == 0 || out_ready_i;
  endfunction

  // Model: a FIFO of capacity CAP; flush and reset empty it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (flush_i[2]) q.delete();
    else begin
      logic a;
      a = in_valid_i && exp_ready();
      if (q.size() > 0 && out_ready_i) void'(q.pop_front());
      if (a) q.push_back(in_data_i);
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready", {31'd0, in_ready_o}, {31'd0, exp_ready()});
    chk("m_out_valid", {31'd0, out_valid_o}, {31'd0, q.size() > 0});
    chk("m_out_data", out_data_o, (q.size() > 0) ? q[0] : NOP);
  end

  task automatic drv(input logic v, input logic [31:0] d, input logic r,
                     input logic st, input logic fl);
    @(posedge clk); #1;
    in_valid_i = v; in_data_i = d; out_ready_i = r;
    stall_i = {3'b000, st, 2'b00}; flush_i = {3'b000, fl, 2'b00};
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset with a pending offer
    in_valid_i = 1'b1; in_data_i = 32'h11;
    at_neg();
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_data", out_data_o, 32'h0000_00A5);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    drv(1, 32'h11, 0, 0, 0);
    drv(0, 0, 1, 0, 0); at_neg();
    chk("lat_valid", {31'd0, out_valid_o}, 32'd1);
    chk("lat_data", out_data_o, 32'h11);

    // Streaming 1..4
    drv(1, 1, 1, 0, 0);
    drv(1, 2, 1, 0, 0); at_neg(); chk("st1", out_data_o, 32'd1);
    drv(1, 3, 1, 0, 0); at_neg(); chk("st2", out_data_o, 32'd2);
    drv(1, 4, 1, 0, 0); at_neg(); chk("st3", out_data_o, 32'd3);
    drv(0, 0, 1, 0, 0); at_neg(); chk("st4", out_data_o, 32'd4);
    drv(0, 0, 1, 0, 0); at_neg(); chk("st_end", {31'd0, out_valid_o}, 32'd0);

    // Bubble under stall
    drv(1, 32'h13, 0, 0, 0);
    drv(0, 0, 1, 1, 0); at_neg();
    chk("bub_held", out_data_o, 32'h13);
    chk("bub_rdy0", {31'd0, in_ready_o}, 32'd0);
    drv(1, 32'h99, 1, 1, 0); at_neg();
    chk("bub_valid", {31'd0, out_valid_o}, 32'd0);
    chk("bub_data", out_data_o, 32'h0000_00A5);
    chk("bub_rdy1", {31'd0, in_ready_o}, 32'd0);

    // Flush with held entry
    drv(1, 32'h55, 0, 0, 0);
    drv(1, 32'hDEAD, 0, 0, 1); at_neg();
    chk("fl_rdy", {31'd0, in_ready_o}, 32'd0);
    chk("fl_held", out_data_o, 32'h55);
    drv(0, 0, 0, 0, 0); at_neg();
    chk("fl_empty", {31'd0, out_valid_o}, 32'd0);
    chk("fl_nop", out_data_o, 32'h0000_00A5);

    // Backpressure during stream 10,11,12
    begin
      logic [31:0] items[3];
      logic        rpat[10];
      int idx;
      items = '{32'd10, 32'd11, 32'd12};
      rpat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      idx = 0;
      got.delete();
      for (int c = 0; c < 10; c++) begin
        drv(idx < 3, (idx < 3) ? items[idx] : 32'd0, rpat[c], 0, 0);
        at_neg();
        if (c == 1) chk("bp_rdy_c1", {31'd0, in_ready_o}, {31'd0, CAP == 2});
        if (c == 2) chk("bp_rdy_c2", {31'd0, in_ready_o}, 32'd0);
        if (out_valid_o && out_ready_i) got.push_back(out_data_o);
        if (in_valid_i && in_ready_o) idx++;
      end
      chk("bp_count", got.size(), 32'd3);
      for (int i = 0; i < 3; i++)
        chk("bp_order", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, items[i]);
    end

    // Fill (skid build holds 6 and 7), then flush
    drv(1, 32'd6, 0, 0, 0);
    drv(1, 32'd7, 0, 0, 0);
    drv(0, 0, 0, 0, 1); at_neg();
    chk("sf_rdy", {31'd0, in_ready_o}, 32'd0);
    chk("sf_head", out_data_o, 32'd6);
    drv(0, 0, 0, 0, 0); at_neg();
    chk("sf_empty", {31'd0, out_valid_o}, 32'd0);
    chk("sf_rdy1", {31'd0, in_ready_o}, 32'd1);

    // Reset mid-transfer
    drv(1, 32'h77, 0, 0, 0);
    @(posedge clk); #1; in_valid_i = 1'b0; rst_n = 1'b0;
    at_neg();
    chk("rm_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rm_data", out_data_o, 32'h0000_00A5);
    @(posedge clk); #1; rst_n = 1'b1;
    drv(0, 0, 1, 0, 0); at_neg();
    chk("rm_after", {31'd0, out_valid_o}, 32'd0);

    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
